// File: rtl/ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm_if
// Brief    : Handshake and strobe bundle between ctrl_fsm and the datapath,
//            instruction memory and data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_fsm_if #(
  parameter int ARCH = 32
);
  // Inputs to the sequencer
  logic [6:0]      op_code_in;
  logic            branch_taken_in;
  logic            imem_ack_in;
  logic            imem_err_in;
  logic            dmem_ack_in;
  logic            dmem_err_in;
  // Outputs of the sequencer
  logic            imem_req_out;
  logic            ir_we_out;
  logic            dmem_req_out;
  logic            dmem_we_out;
  logic            alu_src_b_out;
  logic            rf_we_out;
  logic [1:0]      wb_sel_out;
  logic            pc_we_out;
  logic [1:0]      pc_sel_out;
  logic            trap_out;
  logic [1:0]      trap_cause_out;
  logic [ARCH-1:0] retired_out;

  // Sequencer side
  modport master (
    input  op_code_in, branch_taken_in, imem_ack_in, imem_err_in,
           dmem_ack_in, dmem_err_in,
    output imem_req_out, ir_we_out, dmem_req_out, dmem_we_out,
           alu_src_b_out, rf_we_out, wb_sel_out, pc_we_out, pc_sel_out,
           trap_out, trap_cause_out, retired_out
  );

  // Datapath / memory side
  modport slave (
    output op_code_in, branch_taken_in, imem_ack_in, imem_err_in,
           dmem_ack_in, dmem_err_in,
    input  imem_req_out, ir_we_out, dmem_req_out, dmem_we_out,
           alu_src_b_out, rf_we_out, wb_sel_out, pc_we_out, pc_sel_out,
           trap_out, trap_cause_out, retired_out
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm
// Brief    : Multi-cycle control sequencer for the FRiscV core. Steps each
//            instruction through FETCH/DECODE/EXECUTE/MEM/WB, drives the
//            datapath strobes and memory handshakes, traps on illegal opcodes,
//            bus errors and memory timeouts, and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm #(
  parameter int ARCH        = 32,
  parameter int MEM_TIMEOUT = 255   // legal range 2..1023
) (
  input  wire         clk_in,
  input  wire         rst_in,
  ctrl_fsm_if.master  bus
);

  // RV32I major opcodes recognised by the sequencer
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [9:0] c_timeout   = 10'(MEM_TIMEOUT);

  localparam logic [1:0] c_cause_illegal = 2'b00;
  localparam logic [1:0] c_cause_imem    = 2'b01;
  localparam logic [1:0] c_cause_dmem    = 2'b10;
  localparam logic [1:0] c_cause_timeout = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [6:0]      r_opcode;
  logic            r_branch;
  logic [1:0]      r_cause;
  logic [9:0]      r_wait;
  logic [ARCH-1:0] r_retired;

  logic            w_set_cause;
  logic [1:0]      w_cause;
  logic            w_timeout;

  logic            w_imem_req;
  logic            w_ir_we;
  logic            w_dmem_req;
  logic            w_dmem_we;
  logic            w_alu_src_b;
  logic            w_rf_we;
  logic [1:0]      w_wb_sel;
  logic            w_pc_we;
  logic [1:0]      w_pc_sel;

  function automatic logic f_is_legal(input logic [6:0] op);
    case (op)
      c_op_reg, c_op_imm, c_op_load, c_op_jalr,
      c_op_store, c_op_branch, c_op_lui, c_op_jal: f_is_legal = 1'b1;
      default:                                     f_is_legal = 1'b0;
    endcase
  endfunction

  assign w_timeout = (r_wait == c_timeout);

  // Next-state, trap cause selection and state-decoded outputs
  always_comb begin
    w_next      = r_state;
    w_set_cause = 1'b0;
    w_cause     = r_cause;
    w_imem_req  = 1'b0;
    w_ir_we     = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_alu_src_b = 1'b0;
    w_rf_we     = 1'b0;
    w_wb_sel    = 2'b00;
    w_pc_we     = 1'b0;
    w_pc_sel    = 2'b00;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_we    = bus.imem_ack_in & ~bus.imem_err_in;
        // Error beats ack; either beats the timeout
        if (bus.imem_err_in) begin
          w_next      = S_TRAP;
          w_set_cause = 1'b1;
          w_cause     = c_cause_imem;
        end else if (bus.imem_ack_in) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next      = S_TRAP;
          w_set_cause = 1'b1;
          w_cause     = c_cause_timeout;
        end
      end
      S_DECODE: begin
        if (f_is_legal(bus.op_code_in)) begin
          w_next = S_EXECUTE;
        end else begin
          w_next      = S_TRAP;
          w_set_cause = 1'b1;
          w_cause     = c_cause_illegal;
        end
      end
      S_EXECUTE: begin
        w_alu_src_b = ~((r_opcode == c_op_reg) || (r_opcode == c_op_branch));
        if ((r_opcode == c_op_load) || (r_opcode == c_op_store)) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req  = 1'b1;
        w_dmem_we   = (r_opcode == c_op_store);
        w_alu_src_b = 1'b1;   // address = rs1 + imm for both load and store
        if (bus.dmem_err_in) begin
          w_next      = S_TRAP;
          w_set_cause = 1'b1;
          w_cause     = c_cause_dmem;
        end else if (bus.dmem_ack_in) begin
          w_next = S_WB;
        end else if (w_timeout) begin
          w_next      = S_TRAP;
          w_set_cause = 1'b1;
          w_cause     = c_cause_timeout;
        end
      end
      S_WB: begin
        w_pc_we = 1'b1;
        w_rf_we = ~((r_opcode == c_op_store) || (r_opcode == c_op_branch));
        case (r_opcode)
          c_op_load:          w_wb_sel = 2'b01;
          c_op_jal, c_op_jalr: w_wb_sel = 2'b10;
          c_op_lui:           w_wb_sel = 2'b11;
          default:            w_wb_sel = 2'b00;
        endcase
        case (r_opcode)
          c_op_jal:    w_pc_sel = 2'b01;
          c_op_branch: w_pc_sel = r_branch ? 2'b01 : 2'b00;
          c_op_jalr:   w_pc_sel = 2'b10;
          default:     w_pc_sel = 2'b00;
        endcase
        w_next = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;   // only reset leaves TRAP
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register and wait counter (cleared on every state change)
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
        r_wait <= r_wait + 10'd1;
      end
    end
  end

  // Latched opcode, branch outcome and sticky trap cause
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_opcode <= '0;
      r_branch <= 1'b0;
      r_cause  <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_opcode <= bus.op_code_in;
      end
      if (r_state == S_EXECUTE) begin
        r_branch <= bus.branch_taken_in;
      end
      if (w_set_cause) begin
        r_cause <= w_cause;
      end
    end
  end

  // Retired-instruction counter, bumped on the edge leaving WB
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_retired <= '0;
    end else if (r_state == S_WB) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign bus.imem_req_out   = w_imem_req;
  assign bus.ir_we_out      = w_ir_we;
  assign bus.dmem_req_out   = w_dmem_req;
  assign bus.dmem_we_out    = w_dmem_we;
  assign bus.alu_src_b_out  = w_alu_src_b;
  assign bus.rf_we_out      = w_rf_we;
  assign bus.wb_sel_out     = w_wb_sel;
  assign bus.pc_we_out      = w_pc_we;
  assign bus.pc_sel_out     = w_pc_sel;
  assign bus.trap_out       = (r_state == S_TRAP);
  assign bus.trap_cause_out = r_cause;
  assign bus.retired_out    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_fsm
// Brief    : Self-checking bench for ctrl_fsm. Each instruction is expanded
//            into a per-cycle plan of stimulus and expected outputs from the
//            timing rules (fetch waits, opcode class, memory waits), and
//            every cycle of the plan is compared against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;
  localparam int ARCH = 32;
  localparam int TMO  = 4;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // How a memory phase ends: ack, error, ack+error together, or nothing
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  typedef struct packed {
    logic [6:0] op;
    logic       br;
    logic       iack;
    logic       ierr;
    logic       dack;
    logic       derr;
  } stim_t;

  typedef struct packed {
    logic            imem_req;
    logic            ir_we;
    logic            dmem_req;
    logic            dmem_we;
    logic            alu_src_b;
    logic            rf_we;
    logic [1:0]      wb_sel;
    logic            pc_we;
    logic [1:0]      pc_sel;
    logic            trap;
    logic [1:0]      cause;
    logic [ARCH-1:0] retired;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
    string tag;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_fsm_if #(.ARCH(ARCH)) bus ();

  ctrl_fsm #(.ARCH(ARCH), .MEM_TIMEOUT(TMO)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  rec_t            q[$];
  int              total = 0;
  int              bad   = 0;
  int              trap_hold = 3;
  logic [ARCH-1:0] m_retired = '0;
  logic [1:0]      m_cause   = 2'b00;

  logic [6:0] legal_ops [8] = '{OP_REG, OP_IMM, OP_LOAD, OP_JALR,
                               OP_STORE, OP_BRANCH, OP_LUI, OP_JAL};

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t quiet(input logic br);
    stim_t s;
    s      = '0;
    s.op   = 7'h7f;   // garbage opcode outside DECODE
    s.br   = ~br;     // opposite branch value outside EXECUTE
    return s;
  endfunction

  function automatic exp_t base_exp();
    exp_t e;
    e         = '0;
    e.cause   = m_cause;
    e.retired = m_retired;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g.imem_req  = bus.imem_req_out;
    g.ir_we     = bus.ir_we_out;
    g.dmem_req  = bus.dmem_req_out;
    g.dmem_we   = bus.dmem_we_out;
    g.alu_src_b = bus.alu_src_b_out;
    g.rf_we     = bus.rf_we_out;
    g.wb_sel    = bus.wb_sel_out;
    g.pc_we     = bus.pc_we_out;
    g.pc_sel    = bus.pc_sel_out;
    g.trap      = bus.trap_out;
    g.cause     = bus.trap_cause_out;
    g.retired   = bus.retired_out;
    return g;
  endfunction

  task automatic push(input stim_t s, input exp_t e, input string tag);
    rec_t r;
    r.s = s; r.e = e; r.tag = tag;
    q.push_back(r);
  endtask

  task automatic enter_trap(input logic [1:0] c, input logic br, input string tag);
    exp_t e;
    m_cause = c;
    for (int i = 0; i < trap_hold; i++) begin
      e = base_exp();
      e.trap = 1'b1;
      push(quiet(br), e, {tag, "/trap"});
    end
  endtask

  // Expand one instruction into its cycle-by-cycle plan
  task automatic push_instr(input logic [6:0] op, input int fw, input int fk,
                            input int mw, input int mk, input logic br,
                            input string tag);
    stim_t s;
    exp_t  e;
    int    n;
    n = (fk == K_NONE) ? TMO + 1 : fw + 1;
    for (int i = 0; i < n; i++) begin
      s = quiet(br);
      e = base_exp();
      e.imem_req = 1'b1;
      if (i == n - 1) begin
        s.iack = (fk == K_ACK) || (fk == K_BOTH);
        s.ierr = (fk == K_ERR) || (fk == K_BOTH);
      end
      e.ir_we = s.iack & ~s.ierr;
      push(s, e, {tag, "/fetch"});
    end
    if (fk != K_ACK) begin
      enter_trap((fk == K_NONE) ? 2'b11 : 2'b01, br, tag);
      return;
    end
    s = quiet(br);
    s.op = op;
    push(s, base_exp(), {tag, "/decode"});
    if (!is_legal(op)) begin
      enter_trap(2'b00, br, tag);
      return;
    end
    s = quiet(br);
    s.br = br;
    e = base_exp();
    e.alu_src_b = !(op == OP_REG || op == OP_BRANCH);
    push(s, e, {tag, "/execute"});
    if (op == OP_LOAD || op == OP_STORE) begin
      n = (mk == K_NONE) ? TMO + 1 : mw + 1;
      for (int i = 0; i < n; i++) begin
        s = quiet(br);
        e = base_exp();
        e.dmem_req  = 1'b1;
        e.dmem_we   = (op == OP_STORE);
        e.alu_src_b = 1'b1;
        if (i == n - 1) begin
          s.dack = (mk == K_ACK) || (mk == K_BOTH);
          s.derr = (mk == K_ERR) || (mk == K_BOTH);
        end
        push(s, e, {tag, "/mem"});
      end
      if (mk != K_ACK) begin
        enter_trap((mk == K_NONE) ? 2'b11 : 2'b10, br, tag);
        return;
      end
    end
    e = base_exp();
    e.pc_we  = 1'b1;
    e.rf_we  = !(op == OP_STORE || op == OP_BRANCH);
    e.wb_sel = (op == OP_LOAD) ? 2'b01 :
               (op == OP_JAL || op == OP_JALR) ? 2'b10 :
               (op == OP_LUI) ? 2'b11 : 2'b00;
    e.pc_sel = (op == OP_JAL) ? 2'b01 :
               (op == OP_BRANCH) ? (br ? 2'b01 : 2'b00) :
               (op == OP_JALR) ? 2'b10 : 2'b00;
    push(quiet(br), e, {tag, "/wb"});
    m_retired = m_retired + 1'b1;
  endtask

  task automatic drive(input stim_t s);
    bus.op_code_in      = s.op;
    bus.branch_taken_in = s.br;
    bus.imem_ack_in     = s.iack;
    bus.imem_err_in     = s.ierr;
    bus.dmem_ack_in     = s.dack;
    bus.dmem_err_in     = s.derr;
  endtask

  task automatic check(input string name, input logic [ARCH-1:0] got,
                       input logic [ARCH-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Single compare point: one plan entry per cycle, checked mid-cycle
  task automatic run(input int limit);
    rec_t r;
    exp_t g;
    int   k;
    k = 0;
    while (q.size() > 0 && (limit < 0 || k < limit)) begin
      r = q.pop_front();
      drive(r.s);
      @(negedge clk);
      g = sample();
      total++;
      if (g !== r.e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", r.tag, g, r.e);
      end
      @(posedge clk);
      #2;
      k++;
    end
  endtask

  // Reset, check reset values, release and plan the IDLE cycle
  task automatic do_reset();
    rst = 1'b1;
    drive(quiet(1'b0));
    q.delete();
    m_retired = '0;
    m_cause   = 2'b00;
    @(posedge clk);
    #2;
    check("reset_vector", ARCH'(sample()), '0);
    rst = 1'b0;
    push(quiet(1'b0), base_exp(), "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    drive(quiet(1'b0));
    #1;
    check("reset_retired", bus.retired_out, '0);
    check("reset_trap", ARCH'(bus.trap_out), '0);

    // REG, zero-wait: IDLE + 4 cycles, retired becomes 1
    do_reset();
    push_instr(OP_REG, 0, K_ACK, 0, K_ACK, 1'b0, "reg");
    check("reg_plan_len", ARCH'(q.size()), 32'd5);
    run(-1);
    check("reg_retired", bus.retired_out, 32'd1);

    // LW: 2 fetch waits, 3 mem waits -> 10 cycles
    n0 = q.size();
    push_instr(OP_LOAD, 2, K_ACK, 3, K_ACK, 1'b0, "lw");
    check("lw_plan_len", ARCH'(q.size() - n0), 32'd10);
    run(-1);

    // Remaining classes, both branch outcomes
    push_instr(OP_STORE,  0, K_ACK, 0, K_ACK, 1'b0, "sw");
    push_instr(OP_BRANCH, 0, K_ACK, 0, K_ACK, 1'b1, "beq_t");
    push_instr(OP_BRANCH, 1, K_ACK, 0, K_ACK, 1'b0, "beq_n");
    push_instr(OP_JAL,    0, K_ACK, 0, K_ACK, 1'b0, "jal");
    push_instr(OP_JALR,   0, K_ACK, 0, K_ACK, 1'b1, "jalr");
    push_instr(OP_LUI,    0, K_ACK, 0, K_ACK, 1'b0, "lui");
    push_instr(OP_IMM,    0, K_ACK, 0, K_ACK, 1'b1, "addi");
    // Ack arriving exactly on the last allowed wait cycle is accepted
    push_instr(OP_LOAD,   TMO, K_ACK, TMO, K_ACK, 1'b0, "lw_edge");
    run(-1);
    check("retired_after_mix", bus.retired_out, 32'd10);

    // Asynchronous reset in the middle of MEM
    push_instr(OP_LOAD, 0, K_ACK, 3, K_ACK, 1'b0, "lw_abort");
    run(4);
    drive(quiet(1'b0));
    #1;
    check("abort_in_mem", ARCH'(bus.dmem_req_out), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_dmem_req", ARCH'(bus.dmem_req_out), 32'd0);
    check("abort_alu_src_b", ARCH'(bus.alu_src_b_out), 32'd0);
    check("abort_retired", bus.retired_out, 32'd0);
    do_reset();
    push_instr(OP_REG, 0, K_ACK, 0, K_ACK, 1'b0, "reg_restart");
    run(-1);

    // Retire counter wrap from all-ones
    force dut.r_retired = '1;
    #1;
    release dut.r_retired;
    m_retired = '1;
    push_instr(OP_IMM, 0, K_ACK, 0, K_ACK, 1'b0, "wrap");
    run(-1);
    check("wrap_retired", bus.retired_out, 32'd0);

    // Illegal opcode: trap held for 50 cycles, reset clears it
    trap_hold = 50;
    push_instr(7'b1111111, 0, K_ACK, 0, K_ACK, 1'b0, "illegal");
    run(-1);
    trap_hold = 3;
    check("illegal_trap", ARCH'(bus.trap_out), 32'd1);
    check("illegal_cause", ARCH'(bus.trap_cause_out), 32'd0);
    do_reset();
    check("trap_cleared", ARCH'(bus.trap_out), 32'd0);

    // Same-cycle imem ack and error: error wins, no IR load
    push_instr(OP_REG, 1, K_BOTH, 0, K_ACK, 1'b0, "ack_err");
    run(-1);
    check("ack_err_cause", ARCH'(bus.trap_cause_out), 32'd1);

    // dmem timeout after TMO wait cycles
    do_reset();
    push_instr(OP_LOAD, 0, K_ACK, 0, K_NONE, 1'b0, "dmem_tmo");
    run(-1);
    check("dmem_tmo_cause", ARCH'(bus.trap_cause_out), 32'd3);

    // imem timeout
    do_reset();
    push_instr(OP_REG, 0, K_NONE, 0, K_ACK, 1'b0, "imem_tmo");
    run(-1);

    // dmem error on a store
    do_reset();
    push_instr(OP_STORE, 0, K_ACK, 2, K_ERR, 1'b0, "dmem_err");
    run(-1);
    check("dmem_err_cause", ARCH'(bus.trap_cause_out), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle control sequencer for the FRiscV core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the handshakes and strobes around the shared datapath: instruction register, instr_decode, ALU, register file and PC. It also owns the instruction/data memory request handshakes, traps on illegal opcodes or bus faults, and counts retired instructions.

## Interface
- ARCH, friscv_pkg value (32): datapath width; width of the retire counter.
- MEM_TIMEOUT, 255: maximum wait cycles for an imem/dmem ack before a timeout trap; legal range 2..1023.
- clk_in  in  1  core clock; all state updates on the rising edge.
- rst_in  in  1  reset; asynchronous, active-high.
- op_code_in  in  7  opcode from instr_decode; sampled in DECODE.
- branch_taken_in  in  1  ALU compare result; sampled in EXECUTE.
- imem_req_out  out  1  instruction fetch request.
- imem_ack_in  in  1  fetch data valid this cycle.
- imem_err_in  in  1  fetch bus error.
- ir_we_out  out  1  instruction register load strobe; equals FETCH & imem_ack_in & !imem_err_in (Mealy).
- dmem_req_out  out  1  data memory request.
- dmem_we_out  out  1  data memory write; high with dmem_req_out for STORE only.
- dmem_ack_in  in  1  data access complete.
- dmem_err_in  in  1  data bus error.
- alu_src_b_out  out  1  ALU operand B select: 0 = rs2, 1 = imm.
- rf_we_out  out  1  register file write enable.
- wb_sel_out  out  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 imm.
- pc_we_out  out  1  PC update strobe.
- pc_sel_out  out  2  next PC: 00 PC+4, 01 PC+imm, 10 ALU result.
- trap_out  out  1  sticky trap flag.
- trap_cause_out  out  2  trap cause: 00 illegal opcode, 01 imem error, 10 dmem error, 11 timeout.
- retired_out  out  ARCH  retired-instruction counter; wraps modulo 2^ARCH.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Reset enters IDLE.
- All outputs except ir_we_out are decoded from the state and the latched opcode.
- Reset values: every output 0 and retired_out = 0.
- IDLE: all strobes 0. Moves to FETCH unconditionally on the next edge.
- FETCH: imem_req_out = 1 until ack.
  - imem_err_in → TRAP with cause 01. Error takes priority over a same-cycle ack.
  - ack without error → DECODE.
- DECODE: latches op_code_in.
  - Legal opcodes are REG, IMM_ARITH, IMM_LOAD, IMM_JUMP, STORE, BRANCH, U_L_LOAD and JUMP; a legal opcode → EXECUTE.
  - Any other opcode → TRAP with cause 00.
- EXECUTE: alu_src_b_out = 0 for REG and BRANCH, 1 otherwise. Registers branch_taken_in.
  - IMM_LOAD and STORE → MEM.
  - All other opcodes → WB.
- MEM: dmem_req_out = 1; dmem_we_out = 1 for STORE.
  - dmem_err_in → TRAP with cause 10. Error takes priority over ack.
  - ack → WB.
  - alu_src_b_out stays 1.
- WB: pc_we_out = 1 and retired_out increments; then → FETCH.
  - rf_we_out = 1 for every opcode except STORE and BRANCH.
  - wb_sel_out: REG and IMM_ARITH → 00; IMM_LOAD → 01; JUMP and IMM_JUMP → 10; U_L_LOAD → 11.
  - pc_sel_out: JUMP → 01; BRANCH → 01 if the registered branch_taken is 1, else 00; IMM_JUMP → 10; all others → 00.
- TRAP: all strobes and requests 0, trap_out = 1 and trap_cause_out held. Only reset leaves TRAP.
- Wait counter: cleared on entry to FETCH or MEM and incremented each waiting cycle.
  - No ack by wait cycle MEM_TIMEOUT → TRAP with cause 11.
  - An ack or error in that same cycle takes priority over the timeout.

## Timing
- Zero-wait memory, where the ack arrives in the first request cycle:
  - ALU, LUI, jump and branch instructions take 4 cycles, FETCH to WB.
  - Load and store take 5 cycles.
- Each wait cycle in FETCH or MEM adds 1 cycle.
- The first imem_req_out rises on the 2nd rising edge after rst_in deasserts; the 1st edge moves IDLE to FETCH.
- imem_req_out and dmem_req_out stay high, and their qualifiers stay stable, until the edge on which the ack or error is sampled. They drop in the following cycle.
- rst_in asserted mid-instruction forces IDLE and zeroes all outputs immediately, without waiting for a clock edge. Outstanding memory requests are abandoned.
- retired_out updates on the edge that leaves WB.
- A retire from all-ones wraps to 0.

## Test plan
- Reset, then a REG instruction with ack in the first FETCH cycle → imem_req_out on the 2nd edge and ir_we_out pulsing once. WB is 3 cycles after the ack, with rf_we_out=1, wb_sel_out=00, pc_sel_out=00; retired_out=1.
- LW with imem ack after 2 waits and dmem ack after 3 waits → dmem_req_out high for 4 cycles with dmem_we_out=0. WB has wb_sel_out=01; total 10 cycles.
- SW → dmem_we_out=1 in MEM. BEQ with branch_taken_in=1 → pc_sel_out=01, rf_we_out=0. BEQ with branch_taken_in=0 → pc_sel_out=00.
- Opcode 7'b1111111 → TRAP with cause 00, all strobes 0, and the state stays TRAP for 50 cycles. rst_in then clears trap_out.
- imem_ack_in and imem_err_in high in the same cycle → cause 01 with no ir_we_out. With MEM_TIMEOUT=4 and no dmem ack → TRAP with cause 11 after 4 wait cycles.
- rst_in pulsed mid-MEM → outputs 0 asynchronously, then restart from IDLE. Preload retired_out to all-ones by forcing, retire one instruction → retired_out=0.
